motor_drive_sequencer: RTL and testbench

- Sequences the five shared PWM speed waveforms (full, veer, hard, ninety, ninety-fast) onto the left and right motor H-bridge channels, based on a steering command from the line-sensor logic.
- Debounces the command and inserts dead time on every H-bridge direction reversal.
- Runs the timed two-phase ninety-degree pivot turn.
- Sits between the PWM generator and the motor driver pins.

---
 rtl/motor_drive_sequencer_pkg.sv | 20 ++
 rtl/motor_drive_sequencer_cmd_debouncer.sv | 27 ++
 rtl/motor_drive_sequencer.sv | 103 ++++++++++
 tb/tb_motor_drive_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/motor_drive_sequencer_pkg.sv
// motor_drive_sequencer_pkg: command codes, FSM states, default timings and target helpers
package motor_drive_sequencer_pkg;
  typedef enum logic [2:0] {
    CMD_STOP, CMD_FWD, CMD_VEER_L, CMD_VEER_R,
    CMD_HARD_L, CMD_HARD_R, CMD_NINETY_L, CMD_NINETY_R
  } cmdT;
  typedef enum logic [2:0] {IDLE, DRIVE, DEAD, TURN_FAST, TURN_SLOW} stateT;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_DEAD_CYCLES = 1000;
  localparam int DEF_NINETY_FAST_CYCLES = 2000000;
  localparam int DEF_NINETY_TIMEOUT_CYCLES = 20000000;
  localparam int DEF_CNT_W = 25;
  // {leftDir, rightDir} a command wants; STOP keeps whatever is current
  function automatic logic [1:0] targetDirs(input cmdT c, input logic [1:0] cur);
    return c == CMD_STOP ? cur : c == CMD_NINETY_L ? 2'b10 : c == CMD_NINETY_R ? 2'b01 : 2'b00;
  endfunction
  function automatic stateT targetState(input cmdT c);
    return c == CMD_STOP ? IDLE : (c == CMD_NINETY_L || c == CMD_NINETY_R) ? TURN_FAST : DRIVE;
  endfunction
endpackage

// File: rtl/motor_drive_sequencer_cmd_debouncer.sv
// motor_drive_sequencer_cmd_debouncer: accepts cmd once it has been stable for DEBOUNCE_CYCLES samples
module motor_drive_sequencer_cmd_debouncer
  import motor_drive_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  cmdT  cmd,
  output cmdT  activeCmd
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  cmdT prevCmd;
  logic [CW-1:0] cnt, nextCnt;
  // counts consecutive identical samples, saturating at the threshold
  always_comb nextCnt = cmd != prevCmd ? CW'(1) : cnt == CW'(DEBOUNCE_CYCLES) ? cnt : cnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prevCmd <= CMD_STOP;
      cnt <= '0;
      activeCmd <= CMD_STOP;
    end else begin
      prevCmd <= cmd;
      cnt <= nextCnt;
      if (nextCnt == CW'(DEBOUNCE_CYCLES)) activeCmd <= cmd;
    end
endmodule

// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer: steers shared PWM waveforms onto the H-bridges with dead time
// on direction reversals and a timed two-phase ninety-degree pivot
module motor_drive_sequencer
  import motor_drive_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int NINETY_FAST_CYCLES = DEF_NINETY_FAST_CYCLES,
  parameter int NINETY_TIMEOUT_CYCLES = DEF_NINETY_TIMEOUT_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fullSpeedPwm,
  input  logic       veerSpeedPwm,
  input  logic       hardSpeedPwm,
  input  logic       ninetySpeedPwm,
  input  logic       ninetyFastSpeedPwm,
  input  logic [2:0] cmd,
  input  logic       lineCentered,
  output logic       leftPwm,
  output logic       rightPwm,
  output logic       leftDir,
  output logic       rightDir,
  output logic       turning,
  output logic       turnFault
);
  cmdT activeCmd, curCmd, tgtCmd, nextCurCmd, nextTgtCmd;
  stateT state, nextState;
  logic [CNT_W-1:0] timer, nextTimer;
  logic [1:0] nextDirs;
  logic nextFault, nextLeftPwm, nextRightPwm;

  motor_drive_sequencer_cmd_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debouncer (
    .clk(clk), .rst(rst), .cmd(cmdT'(cmd)), .activeCmd(activeCmd)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      curCmd <= CMD_STOP;
      tgtCmd <= CMD_STOP;
      timer <= '0;
      {leftDir, rightDir} <= 2'b00;
      turnFault <= 1'b0;
      turning <= 1'b0;
      leftPwm <= 1'b0;
      rightPwm <= 1'b0;
    end else begin
      state <= nextState;
      curCmd <= nextCurCmd;
      tgtCmd <= nextTgtCmd;
      timer <= nextTimer;
      {leftDir, rightDir} <= nextDirs;
      turnFault <= nextFault;
      turning <= nextState == TURN_FAST || nextState == TURN_SLOW;
      leftPwm <= nextLeftPwm;
      rightPwm <= nextRightPwm;
    end

  // the active command is re-evaluated every cycle in IDLE/DRIVE, so one latched during a pivot acts afterwards
  always_comb begin
    nextState = state;
    nextCurCmd = curCmd;
    nextTgtCmd = tgtCmd;
    nextDirs = {leftDir, rightDir};
    nextFault = turnFault;
    if (state == IDLE || state == DRIVE) begin
      if (targetDirs(activeCmd, {leftDir, rightDir}) == {leftDir, rightDir}) begin
        nextState = targetState(activeCmd);
        nextCurCmd = activeCmd;
      end else begin
        nextState = DEAD;
        nextTgtCmd = activeCmd;
      end
    end else if (state == DEAD && timer == '0) begin
      nextState = targetState(tgtCmd);
      nextCurCmd = tgtCmd;
      nextDirs = targetDirs(tgtCmd, {leftDir, rightDir});
    end else if (state == TURN_FAST && timer == '0) begin
      nextState = TURN_SLOW;
    end else if (state == TURN_SLOW && (lineCentered || timer == '0)) begin
      nextState = DEAD;
      nextTgtCmd = CMD_FWD;
      nextFault = turnFault | !lineCentered;
    end
    if (nextState == TURN_FAST && state != TURN_FAST) nextFault = 1'b0;
    nextTimer = timer != '0 ? timer - 1'b1 : timer;
    if (nextState != state)
      nextTimer = nextState == DEAD ? CNT_W'(DEAD_CYCLES - 1) :
                  nextState == TURN_FAST ? CNT_W'(NINETY_FAST_CYCLES - 1) :
                  nextState == TURN_SLOW ? CNT_W'(NINETY_TIMEOUT_CYCLES - 1) : '0;
  end

  always_comb begin
    nextLeftPwm = state == TURN_FAST ? ninetyFastSpeedPwm : state == TURN_SLOW ? ninetySpeedPwm :
                  state != DRIVE ? 1'b0 : curCmd == CMD_VEER_L ? veerSpeedPwm :
                  curCmd == CMD_HARD_L ? hardSpeedPwm : fullSpeedPwm;
    nextRightPwm = state == TURN_FAST ? ninetyFastSpeedPwm : state == TURN_SLOW ? ninetySpeedPwm :
                   state != DRIVE ? 1'b0 : curCmd == CMD_VEER_R ? veerSpeedPwm :
                   curCmd == CMD_HARD_R ? hardSpeedPwm : fullSpeedPwm;
  end
endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb_motor_drive_sequencer: directed scenarios with hand-computed cycle-exact expectations
module tb_motor_drive_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] pw = '0;
  logic [2:0] cmd = 3'd0;
  logic lineCentered = 1'b0;
  logic fullSpeedPwm, veerSpeedPwm, hardSpeedPwm, ninetySpeedPwm, ninetyFastSpeedPwm;
  logic leftPwm, rightPwm, leftDir, rightDir, turning, turnFault;
  logic [5:0] outs;
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] STOP = 3'd0, FWD = 3'd1, VEER_L = 3'd2, VEER_R = 3'd3;
  localparam logic [2:0] HARD_L = 3'd4, HARD_R = 3'd5, NINETY_L = 3'd6, NINETY_R = 3'd7;
  localparam logic [2:0] MAP_CMD [5] = '{VEER_L, VEER_R, HARD_L, HARD_R, FWD};
  localparam int MAP_L [5] = '{3, 4, 2, 4, 4};
  localparam int MAP_R [5] = '{4, 3, 4, 2, 4};

  assign {fullSpeedPwm, veerSpeedPwm, hardSpeedPwm, ninetySpeedPwm, ninetyFastSpeedPwm} = pw;
  assign outs = {leftPwm, rightPwm, leftDir, rightDir, turning, turnFault};

  always #5 clk = ~clk;

  motor_drive_sequencer #(
    .DEBOUNCE_CYCLES(4), .DEAD_CYCLES(3), .NINETY_FAST_CYCLES(10),
    .NINETY_TIMEOUT_CYCLES(40), .CNT_W(25)
  ) dut (
    .clk(clk), .rst(rst), .fullSpeedPwm(fullSpeedPwm), .veerSpeedPwm(veerSpeedPwm),
    .hardSpeedPwm(hardSpeedPwm), .ninetySpeedPwm(ninetySpeedPwm),
    .ninetyFastSpeedPwm(ninetyFastSpeedPwm), .cmd(cmd), .lineCentered(lineCentered),
    .leftPwm(leftPwm), .rightPwm(rightPwm), .leftDir(leftDir), .rightDir(rightDir),
    .turning(turning), .turnFault(turnFault)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    tick(2);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL reset_state: got %b expected %b", outs, 6'b000000); end
    rst = 1'b0; cmd = FWD; pw = 5'b10000;
    tick(5);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL reset_latency: got %b expected %b", outs, 6'b000000); end
    tick(1);
    checks++; if (outs !== 6'b110000) begin errors++; $display("FAIL reset_fwd: got %b expected %b", outs, 6'b110000); end
    rst = 1'b1;
    #2;
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL async_reset: got %b expected %b", outs, 6'b000000); end
    tick(1);
    rst = 1'b0;
    tick(5);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL rerelease_idle: got %b expected %b", outs, 6'b000000); end
    tick(1);
    checks++; if (outs !== 6'b110000) begin errors++; $display("FAIL rerelease_fwd: got %b expected %b", outs, 6'b110000); end
  endtask

  task automatic test_debounce;
    cmd = VEER_L;
    tick(3);
    cmd = FWD;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (outs !== 6'b110000) begin errors++; $display("FAIL glitch_ignored[%0d]: got %b expected %b", i, outs, 6'b110000); end
    end
  endtask

  task automatic test_mapping;
    for (int i = 0; i < 5; i++) begin
      cmd = MAP_CMD[i];
      tick(5);
      pw = 5'(1 << MAP_L[i]);
      tick(1);
      checks++; if ({leftPwm, rightPwm} !== {1'b1, MAP_L[i] == MAP_R[i]}) begin errors++; $display("FAIL map_left cmd=%0d: got %b%b expected %b%b", MAP_CMD[i], leftPwm, rightPwm, 1'b1, MAP_L[i] == MAP_R[i]); end
      pw = 5'(1 << MAP_R[i]);
      tick(1);
      checks++; if ({leftPwm, rightPwm} !== {MAP_L[i] == MAP_R[i], 1'b1}) begin errors++; $display("FAIL map_right cmd=%0d: got %b%b expected %b%b", MAP_CMD[i], leftPwm, rightPwm, MAP_L[i] == MAP_R[i], 1'b1); end
    end
  endtask

  task automatic test_ninety;
    pw = 5'b11111; cmd = NINETY_L;
    tick(5);
    checks++; if (outs !== 6'b110000) begin errors++; $display("FAIL ninety_pre: got %b expected %b", outs, 6'b110000); end
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL ninety_dead[%0d]: got %b expected %b", i, outs, 6'b000000); end
    end
    tick(1);
    checks++; if (outs !== 6'b001010) begin errors++; $display("FAIL ninety_dead_exit: got %b expected %b", outs, 6'b001010); end
    cmd = FWD; pw = 5'b00001;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (outs !== 6'b111010) begin errors++; $display("FAIL ninety_fast[%0d]: got %b expected %b", i, outs, 6'b111010); end
    end
    pw = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++; if (outs !== 6'b111010) begin errors++; $display("FAIL ninety_slow[%0d]: got %b expected %b", i, outs, 6'b111010); end
    end
    lineCentered = 1'b1; pw = 5'b11111;
    tick(1);
    checks++; if (outs !== 6'b111000) begin errors++; $display("FAIL exit_line: got %b expected %b", outs, 6'b111000); end
    lineCentered = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++; if (outs !== 6'b001000) begin errors++; $display("FAIL exit_dead[%0d]: got %b expected %b", i, outs, 6'b001000); end
    end
    tick(1);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL exit_dirs: got %b expected %b", outs, 6'b000000); end
    pw = 5'b10000;
    tick(1);
    checks++; if (outs !== 6'b110000) begin errors++; $display("FAIL exit_fwd: got %b expected %b", outs, 6'b110000); end
  endtask

  task automatic test_timeout;
    cmd = NINETY_L; pw = 5'b10000;
    tick(8);
    checks++; if (outs !== 6'b001010) begin errors++; $display("FAIL timeout_enter: got %b expected %b", outs, 6'b001010); end
    cmd = FWD; lineCentered = 1'b1; pw = 5'b00001;
    tick(1);
    checks++; if (outs !== 6'b111010) begin errors++; $display("FAIL fast_ignores_line: got %b expected %b", outs, 6'b111010); end
    lineCentered = 1'b0;
    tick(9);
    checks++; if (outs !== 6'b111010) begin errors++; $display("FAIL fast_end: got %b expected %b", outs, 6'b111010); end
    pw = 5'b00010;
    tick(39);
    checks++; if (outs !== 6'b111010) begin errors++; $display("FAIL pre_timeout: got %b expected %b", outs, 6'b111010); end
    tick(1);
    checks++; if (outs !== 6'b111001) begin errors++; $display("FAIL timeout: got %b expected %b", outs, 6'b111001); end
    pw = 5'b10000;
    tick(4);
    checks++; if (outs !== 6'b110001) begin errors++; $display("FAIL fault_sticky: got %b expected %b", outs, 6'b110001); end
    tick(3);
    checks++; if (outs !== 6'b110001) begin errors++; $display("FAIL fault_sticky_2: got %b expected %b", outs, 6'b110001); end
  endtask

  task automatic test_mid_turn;
    cmd = NINETY_R;
    tick(7);
    checks++; if (outs !== 6'b000001) begin errors++; $display("FAIL dead_fault_held: got %b expected %b", outs, 6'b000001); end
    tick(1);
    checks++; if (outs !== 6'b000110) begin errors++; $display("FAIL pivot_clears_fault: got %b expected %b", outs, 6'b000110); end
    cmd = HARD_R; pw = 5'b00001;
    tick(10);
    checks++; if (outs !== 6'b110110) begin errors++; $display("FAIL hard_r_ignored_fast: got %b expected %b", outs, 6'b110110); end
    pw = 5'b00010;
    tick(39);
    checks++; if (outs !== 6'b110110) begin errors++; $display("FAIL hard_r_ignored_slow: got %b expected %b", outs, 6'b110110); end
    lineCentered = 1'b1;
    tick(1);
    checks++; if (outs !== 6'b110100) begin errors++; $display("FAIL line_beats_timeout: got %b expected %b", outs, 6'b110100); end
    lineCentered = 1'b0;
    tick(3);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL post_pivot_dirs: got %b expected %b", outs, 6'b000000); end
    pw = 5'b10000;
    tick(1);
    checks++; if (outs !== 6'b110000) begin errors++; $display("FAIL post_pivot_fwd: got %b expected %b", outs, 6'b110000); end
    pw = 5'b00100;
    tick(1);
    checks++; if (outs !== 6'b010000) begin errors++; $display("FAIL post_pivot_hard_r: got %b expected %b", outs, 6'b010000); end
  endtask

  task automatic test_reset_dead;
    cmd = NINETY_L; pw = 5'b11111;
    tick(8);
    checks++; if (outs !== 6'b001010) begin errors++; $display("FAIL rd_enter: got %b expected %b", outs, 6'b001010); end
    cmd = FWD;
    tick(10);
    lineCentered = 1'b1;
    tick(1);
    checks++; if (outs !== 6'b111000) begin errors++; $display("FAIL rd_in_dead: got %b expected %b", outs, 6'b111000); end
    lineCentered = 1'b0; rst = 1'b1;
    #2;
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL reset_in_dead: got %b expected %b", outs, 6'b000000); end
    tick(1);
    rst = 1'b0;
    tick(5);
    checks++; if (outs !== 6'b000000) begin errors++; $display("FAIL rd_idle: got %b expected %b", outs, 6'b000000); end
    tick(1);
    checks++; if (outs !== 6'b110000) begin errors++; $display("FAIL rd_recover: got %b expected %b", outs, 6'b110000); end
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_mapping;
    test_ninety;
    test_timeout;
    test_mid_turn;
    test_reset_dead;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
